// File: rtl/flip_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flip_arbiter
// Description : Round-robin sharing of one Flip byte unit between two
//               requesters, with start/finish sequencing and a finish timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ready,
    output logic       o_rsp0_valid,
    output logic       o_rsp1_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_err,
    output logic       o_flip_start,
    output logic [7:0] o_flip_data,
    input  logic [7:0] i_flip_data,
    input  logic       i_flip_finished,
    output logic       o_timeout,
    output logic       o_busy
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_RUN   = 2'd1;
    localparam logic [1:0]       c_ST_RESP  = 2'd2;
    localparam logic [1:0]       c_ST_DRAIN = 2'd3;
    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT_CYC);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last;
    logic             r_port;
    logic [7:0]       r_data;
    logic [7:0]       r_result;
    logic             r_err;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_expired;
    logic             w_grant0;
    logic             w_grant1;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Compare the incremented count so start stays high exactly TIMEOUT_CYC cycles.
    assign w_expired = (w_cnt_inc >= c_TIMEOUT);

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == c_ST_IDLE && !i_rst) begin
            if (i_req0_valid && (!i_req1_valid || r_last)) begin
                w_grant0 = 1'b1;
            end else if (i_req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant0 || w_grant1) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (i_flip_finished || w_expired) w_state_nxt = c_ST_RESP;
            c_ST_RESP:  w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (!i_flip_finished) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= c_ST_IDLE;
            r_last    <= 1'b1;
            r_port    <= 1'b0;
            r_data    <= 8'h00;
            r_result  <= 8'h00;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_data <= w_grant0 ? i_req0_data : i_req1_data;
                        r_port <= w_grant1;
                        r_last <= w_grant1;
                        r_cnt  <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_cnt <= w_cnt_inc;
                    // A finish seen in the expiry cycle still counts as success.
                    if (i_flip_finished) begin
                        r_result <= i_flip_data;
                        r_err    <= 1'b0;
                    end else if (w_expired) begin
                        r_result  <= 8'h00;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    if (!i_flip_finished) r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;
    assign o_flip_start = (r_state == c_ST_RUN);
    assign o_flip_data  = (r_state == c_ST_RUN) ? r_data : 8'h00;
    assign o_rsp0_valid = (r_state == c_ST_RESP) && !r_port;
    assign o_rsp1_valid = (r_state == c_ST_RESP) && r_port;
    assign o_rsp_data   = (r_state == c_ST_RESP) ? r_result : 8'h00;
    assign o_rsp_err    = (r_state == c_ST_RESP) && r_err;
    assign o_timeout    = r_timeout;
    assign o_busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flip_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flip_arbiter
// Description : Directed self-checking bench for flip_arbiter with a
//               bit-reversing Flip model of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flip_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
    logic [7:0] rsp_data, flip_d, flip_q;
    logic       flip_start, flip_finished, timeout_flag, busy;

    int model_lat = 0, model_stale = 0;
    bit model_never = 1'b0;
    int m_cnt, m_hold;
    int cyc = 0;
    int n_cmp = 0, n_err = 0;

    int         acc_port[$], acc_cyc[$];
    int         rsp_port[$], rsp_cyc[$];
    logic [7:0] rsp_data_q[$];
    logic       rsp_err_q[$];
    int         start_cnt = 0, start_first = 0;

    flip_arbiter #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(req0_ready),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(req1_ready),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_flip_start(flip_start), .o_flip_data(flip_d),
        .i_flip_data(flip_q), .i_flip_finished(flip_finished),
        .o_timeout(timeout_flag), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bitrev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Flip model: finishes L cycles after start rises, optionally lingers after start falls
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_hold <= 0;
        end else begin
            m_cnt <= flip_start ? m_cnt + 1 : 0;
            if (flip_start && flip_finished) m_hold <= model_stale;
            else if (m_hold > 0)             m_hold <= m_hold - 1;
        end
    end
    assign flip_finished = (flip_start && !model_never && (m_cnt >= model_lat)) || (m_hold != 0);
    assign flip_q = bitrev(flip_d);

    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready || req1_ready) begin
                n_cmp++;
                assert (!(req0_ready && req1_ready)) else begin
                    n_err++;
                    $error("FAIL ready_exclusive: observed both ready high, expected at most one");
                end
            end
            if (req0_ready) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
            if (req1_ready) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
            if (rsp0_valid || rsp1_valid) begin
                rsp_port.push_back(rsp1_valid ? 1 : 0);
                rsp_cyc.push_back(cyc);
                rsp_data_q.push_back(rsp_data);
                rsp_err_q.push_back(rsp_err);
            end
            if (flip_start) begin
                if (start_cnt == 0) start_first = cyc;
                start_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        acc_port.delete(); acc_cyc.delete();
        rsp_port.delete(); rsp_cyc.delete();
        rsp_data_q.delete(); rsp_err_q.delete();
        start_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        model_lat = 0; model_never = 1'b0; model_stale = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k = 0;
        while (acc_port.size() < n && k < 200) begin @(posedge clk); #1; k++; end
        chk({tag, "_accept_seen"}, 32'(acc_port.size() >= n), 1);
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int k = 0;
        while (rsp_port.size() < n && k < 200) begin @(posedge clk); #1; k++; end
        chk({tag, "_rsp_seen"}, 32'(rsp_port.size() >= n), 1);
    endtask

    initial begin
        // Reset state, with a request pending that must not be acknowledged
        v0 = 1'b1; d0 = 8'h23;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", flip_start, 0);
        chk("rst_timeout", timeout_flag, 0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp_err}, 0);

        // 1: single request, L=3
        do_reset();
        model_lat = 3; v0 = 1'b1; d0 = 8'h23;
        wait_acc(1, "t1");
        v0 = 1'b0;
        wait_rsp(1, "t1");
        chk("t1_port", acc_port[0], 0);
        chk("t1_start_first", start_first - acc_cyc[0], 1);
        chk("t1_start_cnt", start_cnt, 4);
        chk("t1_rsp_lat", rsp_cyc[0] - acc_cyc[0], 5);
        chk("t1_rsp_port", rsp_port[0], 0);
        chk("t1_rsp_data", rsp_data_q[0], 8'hC4);
        chk("t1_rsp_err", rsp_err_q[0], 0);

        // 2: simultaneous requests
        do_reset();
        model_lat = 1; v0 = 1'b1; d0 = 8'hAB; v1 = 1'b1; d1 = 8'h5D;
        wait_acc(2, "t2");
        v0 = 1'b0; v1 = 1'b0;
        wait_rsp(2, "t2");
        chk("t2_first_port", acc_port[0], 0);
        chk("t2_second_port", acc_port[1], 1);
        chk("t2_spacing_ge4", 32'((acc_cyc[1] - acc_cyc[0]) >= 4), 1);
        chk("t2_rsp0_port", rsp_port[0], 0);
        chk("t2_rsp0_data", rsp_data_q[0], 8'hD5);
        chk("t2_rsp1_port", rsp_port[1], 1);
        chk("t2_rsp1_data", rsp_data_q[1], 8'hBA);

        // 3: fairness with both held, L=0 gives minimum spacing
        do_reset();
        model_lat = 0; v0 = 1'b1; d0 = 8'h0F; v1 = 1'b1; d1 = 8'hF0;
        wait_acc(6, "t3");
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), acc_port[i], i % 2);
        chk("t3_min_spacing", acc_cyc[1] - acc_cyc[0], 4);
        wait_rsp(6, "t3");
        chk("t3_rsp1_data", rsp_data_q[1], 8'h0F);

        // 4: timeout, then recovery
        do_reset();
        model_never = 1'b1; v1 = 1'b1; d1 = 8'h11;
        wait_acc(1, "t4");
        v1 = 1'b0;
        wait_rsp(1, "t4");
        chk("t4_start_cnt", start_cnt, 8);
        chk("t4_rsp_lat", rsp_cyc[0] - acc_cyc[0], 9);
        chk("t4_rsp_port", rsp_port[0], 1);
        chk("t4_rsp_data", rsp_data_q[0], 8'h00);
        chk("t4_rsp_err", rsp_err_q[0], 1);
        chk("t4_timeout_flag", timeout_flag, 1);
        model_never = 1'b0; model_lat = 2; v0 = 1'b1; d0 = 8'h01;
        wait_acc(2, "t4b");
        v0 = 1'b0;
        wait_rsp(2, "t4b");
        chk("t4b_rsp_port", rsp_port[1], 0);
        chk("t4b_rsp_data", rsp_data_q[1], 8'h80);
        chk("t4b_rsp_err", rsp_err_q[1], 0);
        chk("t4b_timeout_sticky", timeout_flag, 1);

        // 5: finished lingers 3 cycles after start falls
        do_reset();
        model_lat = 1; model_stale = 3; v0 = 1'b1; d0 = 8'h12;
        wait_acc(2, "t5");
        v0 = 1'b0;
        chk("t5_rsp_data", rsp_data_q[0], 8'h48);
        chk("t5_spacing", acc_cyc[1] - acc_cyc[0], 7);

        // 6: reset two cycles after an accept
        do_reset();
        model_lat = 5; v0 = 1'b1; d0 = 8'h55;
        wait_acc(1, "t6");
        @(posedge clk); #1;
        chk("t6_start_before_rst", flip_start, 1);
        rst = 1'b1; v1 = 1'b1; d1 = 8'h0F;
        #1;
        chk("t6_rst_start", flip_start, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, flip_d, rsp_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_rsp", rsp_port.size(), 0);
        rst = 1'b0;
        clear_logs();
        wait_acc(1, "t6b");
        v0 = 1'b0; v1 = 1'b0;
        chk("t6_tie_port", acc_port[0], 0);
        wait_rsp(1, "t6b");
        chk("t6_rsp_data", rsp_data_q[0], 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
